// File: rtl/countdown_timer.sv
// Countdown timer: loads a clamped delay, decrements once every TICK_DIV cycles,
// and flags expiry with a held level plus a one-cycle strobe (optionally auto-reloading).
module countdown_timer #(
   parameter int WIDTH     = 12,
   parameter int MIN_COUNT = 100,
   parameter int TICK_DIV  = 1,
   parameter int RELOAD    = 0
) (
   input  logic             clk1k,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] num,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             countdown_finish,
   output logic             finish_pulse,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOADED = 3'd1,
      S_RUN    = 3'd2,
      S_PAUSED = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam int               DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_COUNT);
   localparam logic [DW-1:0]    DIV_LAST = DW'(TICK_DIV - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [DW-1:0]    div_q, div_d;
   logic             fin_q, fin_d;
   logic             pulse_q, pulse_d;

   logic [WIDTH-1:0] load_val;
   logic             tick;

   assign load_val = (num < MIN_V) ? MIN_V : num;
   assign tick     = (div_q == DIV_LAST);

   always_ff @(posedge clk1k or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         div_q    <= '0;
         fin_q    <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         div_q    <= div_d;
         fin_q    <= fin_d;
         pulse_q  <= pulse_d;
      end
   end

   // Priority is abort > load > start > pause; each state only looks at the inputs it accepts.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      div_d    = div_q;
      fin_d    = fin_q;
      pulse_d  = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
         count_d = '0;
         fin_d   = 1'b0;
         div_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (load) begin
                  state_d  = S_LOADED;
                  count_d  = load_val;
                  reload_d = load_val;
                  fin_d    = 1'b0;
               end
            end
            S_LOADED: begin
               if (start) begin
                  state_d = S_RUN;
                  div_d   = '0;
               end
            end
            S_RUN, S_PAUSED: begin
               // The resume cycle counts as a running cycle, so a pause held for P
               // cycles delays expiry by exactly P.
               if (pause) begin
                  state_d = S_PAUSED;
               end else begin
                  state_d = S_RUN;
                  if (tick) begin
                     div_d = '0;
                     if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                     end else begin
                        pulse_d = 1'b1;
                        fin_d   = 1'b1;
                        if (RELOAD != 0) begin
                           count_d = reload_q;
                        end else begin
                           state_d = S_DONE;
                        end
                     end
                  end else begin
                     div_d = div_q + DW'(1);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign count            = count_q;
   assign busy             = (state_q == S_RUN) || (state_q == S_PAUSED);
   assign countdown_finish = fin_q;
   assign finish_pulse     = pulse_q;
   assign state_dbg        = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: three instances (one-shot, divided tick, auto-reload);
// expected pulse cycles are queued by stimulus and consumed by a pulse monitor.
module tb_countdown_timer;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOADED = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_PAUSED = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic        clk = 1'b0;
   logic [31:0] cyc = 32'd0;

   logic        rst[3];
   logic        ld[3];
   logic        st[3];
   logic        pa[3];
   logic        ab[3];
   logic [11:0] nm[3];
   logic [11:0] cnt[3];
   logic        bsy[3];
   logic        fin[3];
   logic        pls[3];
   logic [2:0]  sdbg[3];

   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   logic [31:0] exp_q2[$];

   int checks   = 0;
   int failures = 0;
   int e0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   countdown_timer #(.WIDTH(12), .MIN_COUNT(100), .TICK_DIV(1), .RELOAD(0)) dut0 (
      .clk1k(clk), .rst_n(rst[0]), .load(ld[0]), .num(nm[0]), .start(st[0]),
      .pause(pa[0]), .abort(ab[0]), .count(cnt[0]), .busy(bsy[0]),
      .countdown_finish(fin[0]), .finish_pulse(pls[0]), .state_dbg(sdbg[0]));

   countdown_timer #(.WIDTH(12), .MIN_COUNT(100), .TICK_DIV(4), .RELOAD(0)) dut1 (
      .clk1k(clk), .rst_n(rst[1]), .load(ld[1]), .num(nm[1]), .start(st[1]),
      .pause(pa[1]), .abort(ab[1]), .count(cnt[1]), .busy(bsy[1]),
      .countdown_finish(fin[1]), .finish_pulse(pls[1]), .state_dbg(sdbg[1]));

   countdown_timer #(.WIDTH(12), .MIN_COUNT(100), .TICK_DIV(1), .RELOAD(1)) dut2 (
      .clk1k(clk), .rst_n(rst[2]), .load(ld[2]), .num(nm[2]), .start(st[2]),
      .pause(pa[2]), .abort(ab[2]), .count(cnt[2]), .busy(bsy[2]),
      .countdown_finish(fin[2]), .finish_pulse(pls[2]), .state_dbg(sdbg[2]));

   task automatic check(input string name, input int d, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, d, act, exp, cyc);
      end
   endtask

   task automatic pop_exp(input int d, output logic ok, output logic [31:0] v);
      ok = 1'b1;
      v  = '0;
      case (d)
         0:       if (exp_q0.size() > 0) v = exp_q0.pop_front(); else ok = 1'b0;
         1:       if (exp_q1.size() > 0) v = exp_q1.pop_front(); else ok = 1'b0;
         default: if (exp_q2.size() > 0) v = exp_q2.pop_front(); else ok = 1'b0;
      endcase
   endtask

   // Pulse monitor: every finish_pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      logic        ok;
      logic [31:0] v;
      for (int d = 0; d < 3; d++) begin
         if (pls[d]) begin
            pop_exp(d, ok, v);
            if (!ok) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse dut%0d: pulse at cycle %0d, none expected", d, cyc);
            end else begin
               check("pulse_cycle", d, int'(cyc), int'(v));
               check("finish_with_pulse", d, int'(fin[d]), 1);
            end
         end
      end
   end

   task automatic wait_until(input int c);
      while (int'(cyc) < c) @(negedge clk);
   endtask

   task automatic load_num(input int d, input logic [11:0] v);
      @(negedge clk);
      ld[d] = 1'b1;
      nm[d] = v;
      @(negedge clk);
      ld[d] = 1'b0;
   endtask

   task automatic start_run(input int d, output int edge_cyc);
      @(negedge clk);
      st[d] = 1'b1;
      @(posedge clk);
      #1;
      st[d] = 1'b0;
      edge_cyc = int'(cyc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b0; ld[d] = 1'b0; st[d] = 1'b0;
         pa[d]  = 1'b0; ab[d] = 1'b0; nm[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) rst[d] = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset_count", d, int'(cnt[d]), 0);
         check("reset_busy", d, int'(bsy[d]), 0);
         check("reset_finish", d, int'(fin[d]), 0);
         check("reset_pulse", d, int'(pls[d]), 0);
         check("reset_state", d, int'(sdbg[d]), int'(ST_IDLE));
      end

      // One-shot, num=500: expiry at E0+501; load during RUN is ignored.
      load_num(0, 12'd500);
      check("load_count", 0, int'(cnt[0]), 500);
      check("load_state", 0, int'(sdbg[0]), int'(ST_LOADED));
      start_run(0, e0);
      exp_q0.push_back(32'(e0 + 501));
      check("count_at_start", 0, int'(cnt[0]), 500);
      check("busy_run", 0, int'(bsy[0]), 1);
      wait_until(e0 + 10);
      check("count_run10", 0, int'(cnt[0]), 490);
      ld[0] = 1'b1;
      nm[0] = 12'd7;
      @(posedge clk);
      #1;
      ld[0] = 1'b0;
      check("load_in_run_count", 0, int'(cnt[0]), 489);
      check("load_in_run_state", 0, int'(sdbg[0]), int'(ST_RUN));
      wait_until(e0 + 500);
      check("count_zero", 0, int'(cnt[0]), 0);
      check("busy_before_expiry", 0, int'(bsy[0]), 1);
      check("finish_before_expiry", 0, int'(fin[0]), 0);
      @(negedge clk);
      check("finish_at_expiry", 0, int'(fin[0]), 1);
      check("busy_at_expiry", 0, int'(bsy[0]), 0);
      check("state_done", 0, int'(sdbg[0]), int'(ST_DONE));
      wait_until(e0 + 503);
      check("finish_held", 0, int'(fin[0]), 1);
      check("pulse_low_after", 0, int'(pls[0]), 0);
      check("count_held_done", 0, int'(cnt[0]), 0);

      // Clamp: num=20 becomes 100, expiry 101 cycles after start.
      load_num(0, 12'd20);
      check("clamp_count", 0, int'(cnt[0]), 100);
      check("finish_cleared_by_load", 0, int'(fin[0]), 0);
      start_run(0, e0);
      exp_q0.push_back(32'(e0 + 101));
      wait_until(e0 + 100);
      check("clamp_count_zero", 0, int'(cnt[0]), 0);
      @(negedge clk);
      check("clamp_expiry_state", 0, int'(sdbg[0]), int'(ST_DONE));

      // load+start together: load wins, no countdown.
      @(negedge clk);
      ld[0] = 1'b1; st[0] = 1'b1; nm[0] = 12'd300;
      @(negedge clk);
      ld[0] = 1'b0; st[0] = 1'b0;
      check("loadstart_state", 0, int'(sdbg[0]), int'(ST_LOADED));
      repeat (5) @(negedge clk);
      check("loadstart_count_held", 0, int'(cnt[0]), 300);
      check("loadstart_busy", 0, int'(bsy[0]), 0);

      // Abort exactly on the expiry edge (E0+301): no pulse, back to IDLE.
      start_run(0, e0);
      wait_until(e0 + 300);
      ab[0] = 1'b1;
      @(posedge clk);
      #1;
      ab[0] = 1'b0;
      check("abort_expiry_state", 0, int'(sdbg[0]), int'(ST_IDLE));
      check("abort_expiry_count", 0, int'(cnt[0]), 0);
      check("abort_expiry_finish", 0, int'(fin[0]), 0);
      check("abort_expiry_pulse", 0, int'(pls[0]), 0);
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-run, then start without load is ignored.
      load_num(0, 12'd200);
      start_run(0, e0);
      wait_until(e0 + 20);
      check("pre_reset_count", 0, int'(cnt[0]), 180);
      @(negedge clk);
      #2;
      rst[0] = 1'b0;
      #1;
      check("async_reset_count", 0, int'(cnt[0]), 0);
      check("async_reset_busy", 0, int'(bsy[0]), 0);
      check("async_reset_state", 0, int'(sdbg[0]), int'(ST_IDLE));
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      check("start_no_load_state", 0, int'(sdbg[0]), int'(ST_IDLE));
      check("start_no_load_busy", 0, int'(bsy[0]), 0);

      // TICK_DIV=4, N=100, pause for 37 edges starting on a tick edge: expiry E0+441.
      load_num(1, 12'd100);
      check("div_load_count", 1, int'(cnt[1]), 100);
      start_run(1, e0);
      exp_q1.push_back(32'(e0 + 441));
      wait_until(e0 + 48);
      check("div_count_48", 1, int'(cnt[1]), 88);
      wait_until(e0 + 51);
      pa[1] = 1'b1;
      @(negedge clk);
      check("pause_on_tick_count", 1, int'(cnt[1]), 88);
      check("pause_state", 1, int'(sdbg[1]), int'(ST_PAUSED));
      check("pause_busy", 1, int'(bsy[1]), 1);
      wait_until(e0 + 88);
      check("pause_frozen_count", 1, int'(cnt[1]), 88);
      pa[1] = 1'b0;
      @(negedge clk);
      check("resume_count", 1, int'(cnt[1]), 87);
      check("resume_state", 1, int'(sdbg[1]), int'(ST_RUN));
      wait_until(e0 + 440);
      check("div_count_zero", 1, int'(cnt[1]), 0);
      check("div_finish_before", 1, int'(fin[1]), 0);
      wait_until(e0 + 442);
      check("div_state_done", 1, int'(sdbg[1]), int'(ST_DONE));
      check("div_finish", 1, int'(fin[1]), 1);

      // RELOAD=1, N=150: pulses at E0+151, +302, +453; finish stays high.
      load_num(2, 12'd150);
      start_run(2, e0);
      exp_q2.push_back(32'(e0 + 151));
      exp_q2.push_back(32'(e0 + 302));
      exp_q2.push_back(32'(e0 + 453));
      wait_until(e0 + 200);
      check("reload_count_200", 2, int'(cnt[2]), 101);
      check("reload_finish_held", 2, int'(fin[2]), 1);
      check("reload_busy", 2, int'(bsy[2]), 1);
      wait_until(e0 + 454);
      check("reload_count_454", 2, int'(cnt[2]), 149);
      check("reload_state_run", 2, int'(sdbg[2]), int'(ST_RUN));
      @(negedge clk);
      ab[2] = 1'b1;
      @(negedge clk);
      ab[2] = 1'b0;
      check("reload_abort_state", 2, int'(sdbg[2]), int'(ST_IDLE));
      check("reload_abort_count", 2, int'(cnt[2]), 0);
      check("reload_abort_finish", 2, int'(fin[2]), 0);

      repeat (5) @(negedge clk);
      check("pending_pulses", 0, exp_q0.size(), 0);
      check("pending_pulses", 1, exp_q1.size(), 0);
      check("pending_pulses", 2, exp_q2.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
